psum_accum_ctrl: RTL and testbench
==================================

Name: psum_accum_ctrl

Overview:
- Parametrised read-modify-write controller sitting between the OFIFO output and the single-port psum SRAM in the core.
- Replaces the fixed OFIFO-to-SRAM write path, which can only overwrite, with a sequenced transfer of a run of psum vectors to consecutive SRAM addresses.
- Two transfer modes: overwrite (first tile pass) or per-lane signed accumulate (later passes over K tiles), with optional saturation.

Parameters:
- col, 8, number of psum lanes per vector
- psum_bw, 16, signed width of each lane
- addr_bw, 11, SRAM address width (depth 2^addr_bw)
- sat_en, 1, 1 = saturating accumulate, 0 = wrap-around accumulate

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE
- mode  input  1  0 = overwrite, 1 = accumulate; latched at start
- base_addr  input  addr_bw  first SRAM address; latched at start
- length  input  addr_bw+1  vectors in run (0..2^addr_bw); latched at start
- in_valid  input  1  OFIFO has a vector
- in_data  input  psum_bw*col  psum vector; lane i is bits [psum_bw*(i+1)-1 : psum_bw*i]
- in_ready  output  1  controller accepts in_data this cycle
- mem_cen  output  1  SRAM chip enable, active low
- mem_wen  output  1  SRAM write enable, active low (1 = read)
- mem_addr  output  addr_bw  SRAM address
- mem_d  output  psum_bw*col  SRAM write data
- mem_q  input  psum_bw*col  SRAM read data, valid the cycle after a read is sampled
- busy  output  1  high in any state but IDLE
- done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset (asserted low):
  - state = IDLE; address and count registers = 0; hold register = 0.
  - Outputs: in_ready = 0, mem_cen = 1, mem_wen = 1, mem_addr = 0, mem_d = 0, busy = 0, done = 0.
  - Reset asserted mid-run aborts the run immediately; no further SRAM access occurs.
- States: IDLE, OVW, RD, WB, DONE.
- IDLE:
  - If start = 1 and length = 0, go to DONE.
  - If start = 1 and length > 0: go to OVW (mode = 0) or RD (mode = 1); cur_addr = base_addr; cnt = 0.
- Memory outputs are combinational from state and registers. mem_cen = 1 except in the access cycles defined below.
- OVW:
  - in_ready = 1.
  - On in_valid: mem_cen = 0, mem_wen = 0, mem_addr = cur_addr, mem_d = in_data.
  - At the edge: cur_addr += 1, cnt += 1. If cnt == length-1, go to DONE.
  - Throughput 1 vector/cycle.
- RD:
  - in_ready = 1.
  - On in_valid: mem_cen = 0, mem_wen = 1, mem_addr = cur_addr; latch in_data into the hold register; go to WB.
  - No in_valid: stay in RD, mem_cen = 1.
- WB:
  - in_ready = 0; mem_cen = 0, mem_wen = 0, mem_addr = cur_addr.
  - mem_d lane i = hold_i + mem_q_i, signed psum_bw-bit.
  - At the edge: cur_addr += 1, cnt += 1. Go to DONE if cnt == length-1, else RD.
  - Throughput 1 vector per 2 cycles. No read-after-write hazard, because each write completes before the next read.
- Arithmetic:
  - Compute the sum at psum_bw+1 bits.
  - sat_en = 1: clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - sat_en = 0: truncate to psum_bw bits.
  - Lanes are independent.
- Address wrap: cur_addr increments modulo 2^addr_bw. A run crossing the top address wraps to 0.
- DONE: done = 1 for exactly one cycle, busy = 1, then go to IDLE.
- Boundary conditions:
  - start while busy is ignored. Inputs are latched only in IDLE.
  - mode, base_addr and length changes during a run have no effect.
  - length = 2^addr_bw covers every address once.
  - in_valid deasserted mid-run stalls with no SRAM access. The run resumes when in_valid returns.

Test Plan:
- Overwrite run: reset, start mode=0 base=0x010 len=4, in_valid held with vectors V0..V3 -> writes at 0x010..0x013 on 4 consecutive cycles, mem_d = Vn; done pulses the cycle after the last write; busy falls with done.
- Accumulate, no overflow: preload 0x020 with all lanes = 100; start mode=1 base=0x020 len=1, in lanes = -30 -> one read of 0x020, then a write of all lanes = 70; in_ready low during WB.
- Saturation and wrap: sat_en=1, mem lane = 32000, in = 1000 -> 32767; mem = -32000, in = -1000 -> -32768; same with sat_en=0 -> -32536 and 32536.
- Address wrap: base=0x7FE len=3 overwrite -> writes at 0x7FE, 0x7FF, 0x000.
- Stall and ignored start: accumulate len=3 with in_valid low for 5 cycles after the first vector -> mem_cen stays 1 during the stall and the results are correct; a start pulse mid-run causes no restart; len=0 start -> done one cycle later with no mem_cen = 0.
- Reset mid-run: assert reset during WB of vector 1 of 4 -> outputs return to reset values asynchronously, with no further writes; a new run after release behaves normally.

Source files
------------

// File: rtl/psum_accum_ctrl_if.sv
// OFIFO-to-controller psum vector stream; a vector moves on a cycle where in_valid and in_ready are both high.
interface psum_accum_ctrl_if #(
  parameter int dw = 128
);
  logic          in_valid;
  logic [dw-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/psum_accum_ctrl.sv
// Psum SRAM read-modify-write sequencer: overwrite at 1 vector/cycle, or per-lane accumulate at 1 vector/2 cycles
// (read, then write back). in_ready is low during write-back; a stall on in_valid issues no SRAM access.
module psum_accum_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter bit sat_en  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw:0]         length,
  psum_accum_ctrl_if.slave         inIf,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic [addr_bw-1:0]       mem_addr,
  output logic [psum_bw*col-1:0]   mem_d,
  input  logic [psum_bw*col-1:0]   mem_q,
  output logic                     busy,
  output logic                     done
);

  localparam int dataBw = psum_bw * col;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] OVW  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [addr_bw-1:0] addrOne = 1;
  localparam logic [addr_bw:0]   cntOne  = 1;

  logic [2:0]         state;
  logic [2:0]         stateNxt;
  logic [addr_bw-1:0] curAddr;
  logic [addr_bw:0]   cnt;
  logic [addr_bw:0]   lenReg;
  logic [dataBw-1:0]  holdReg;
  logic [dataBw-1:0]  sumVec;
  logic               lastVec;

  logic signed [psum_bw-1:0] holdLane;
  logic signed [psum_bw-1:0] qLane;
  logic signed [psum_bw:0]   laneSum;

  // lenReg is nonzero whenever this is consulted, so the subtraction never underflows.
  assign lastVec = (cnt == lenReg - cntOne);

  // One extra bit holds the exact sum; overflow at psum_bw shows as differing top two bits.
  always_comb begin
    sumVec   = '0;
    holdLane = '0;
    qLane    = '0;
    laneSum  = '0;
    for (int i = 0; i < col; i++) begin
      holdLane = holdReg[i*psum_bw +: psum_bw];
      qLane    = mem_q[i*psum_bw +: psum_bw];
      laneSum  = (psum_bw+1)'(holdLane) + (psum_bw+1)'(qLane);
      if (sat_en && (laneSum[psum_bw] != laneSum[psum_bw-1])) begin
        sumVec[i*psum_bw +: psum_bw] = laneSum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                         : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
        sumVec[i*psum_bw +: psum_bw] = laneSum[psum_bw-1:0];
      end
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) stateNxt = DONE;
          else              stateNxt = mode ? RD : OVW;
        end
      end
      OVW:     if (inIf.in_valid && lastVec) stateNxt = DONE;
      RD:      if (inIf.in_valid) stateNxt = WB;
      WB:      stateNxt = lastVec ? DONE : RD;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      curAddr <= '0;
      cnt     <= '0;
      lenReg  <= '0;
      holdReg <= '0;
    end else begin
      state <= stateNxt;
      case (state)
        IDLE: begin
          if (start) begin
            curAddr <= base_addr;
            cnt     <= '0;
            lenReg  <= length;
          end
        end
        OVW: begin
          if (inIf.in_valid) begin
            curAddr <= curAddr + addrOne;
            cnt     <= cnt + cntOne;
          end
        end
        RD: begin
          if (inIf.in_valid) holdReg <= inIf.in_data;
        end
        WB: begin
          curAddr <= curAddr + addrOne;
          cnt     <= cnt + cntOne;
        end
        default: ;
      endcase
    end
  end

  // The read issued in RD returns on mem_q during WB, where it is summed and written back.
  always_comb begin
    inIf.in_ready = 1'b0;
    mem_cen       = 1'b1;
    mem_wen       = 1'b1;
    mem_addr      = curAddr;
    mem_d         = '0;
    case (state)
      OVW: begin
        inIf.in_ready = 1'b1;
        if (inIf.in_valid) begin
          mem_cen = 1'b0;
          mem_wen = 1'b0;
          mem_d   = inIf.in_data;
        end
      end
      RD: begin
        inIf.in_ready = 1'b1;
        if (inIf.in_valid) mem_cen = 1'b0;
      end
      WB: begin
        mem_cen = 1'b0;
        mem_wen = 1'b0;
        mem_d   = sumVec;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench: saturating and wrapping controllers driven side by side, each checked against a golden memory image.
module tb_psum_accum_ctrl;

  typedef struct packed {
    logic [10:0]  a;
    logic [127:0] d;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [10:0]  base_addr;
  logic [11:0]  length;

  logic         cenS, wenS, busyS, doneS;
  logic [10:0]  addrS;
  logic [127:0] dS, qS;
  logic         cenW, wenW, busyW, doneW;
  logic [10:0]  addrW;
  logic [127:0] dW, qW;

  logic [127:0] ramS [0:2047];
  logic [127:0] ramW [0:2047];
  logic [127:0] goldS [0:2047];
  logic [127:0] goldW [0:2047];

  logic         fillAll;
  logic         plVld;
  logic [10:0]  plAddr;
  logic [127:0] plDat;

  wr_t          wqS[$];
  wr_t          wqW[$];
  logic [10:0]  rqS[$];
  logic [10:0]  rqW[$];
  logic [127:0] vecQ[$];

  int nCmp = 0;
  int nBad = 0;

  psum_accum_ctrl_if #(.dw(128)) ifS ();
  psum_accum_ctrl_if #(.dw(128)) ifW ();

  psum_accum_ctrl #(.col(8), .psum_bw(16), .addr_bw(11), .sat_en(1'b1)) dutSat (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr), .length(length),
    .inIf(ifS), .mem_cen(cenS), .mem_wen(wenS), .mem_addr(addrS), .mem_d(dS), .mem_q(qS),
    .busy(busyS), .done(doneS)
  );

  psum_accum_ctrl #(.col(8), .psum_bw(16), .addr_bw(11), .sat_en(1'b0)) dutWrap (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr), .length(length),
    .inIf(ifW), .mem_cen(cenW), .mem_wen(wenW), .mem_addr(addrW), .mem_d(dW), .mem_q(qW),
    .busy(busyW), .done(doneW)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: time %0t, required finish before 1000000", $time);
    $fatal(1);
  end

  function automatic logic [127:0] fillVec(input int a);
    return {32'(a * 32'h9E3779B1), 32'(a * 32'h85EBCA6B), 32'(a * 32'hC2B2AE35), 32'(a * 32'h27D4EB2F)};
  endfunction

  function automatic logic [127:0] randVec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference accumulate: plain integer lane sums, optionally clamped to the 16-bit signed range.
  function automatic logic [127:0] accVec(input logic [127:0] old, input logic [127:0] v, input bit sat);
    logic [127:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = int'($signed(old[i*16 +: 16])) + int'($signed(v[i*16 +: 16]));
      if (sat && s > 32767)  s = 32767;
      if (sat && s < -32768) s = -32768;
      r[i*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  // SRAM models: one-cycle read latency, write on the edge.
  always @(posedge clk) begin
    if (fillAll) begin
      for (int a = 0; a < 2048; a++) begin
        ramS[a] <= fillVec(a);
        ramW[a] <= fillVec(a);
      end
    end else if (plVld) begin
      ramS[plAddr] <= plDat;
      ramW[plAddr] <= plDat;
    end
    if (!cenS) begin
      if (!wenS) ramS[addrS] <= dS;
      else       qS <= ramS[addrS];
    end
    if (!cenW) begin
      if (!wenW) ramW[addrW] <= dW;
      else       qW <= ramW[addrW];
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkPort(input bit sat, input logic cen, input logic wen,
                         input logic [10:0] a, input logic [127:0] d);
    wr_t         e;
    logic [10:0] ra;
    int          sz;
    if (cen !== 1'b0) return;
    if (wen === 1'b0) begin
      sz = sat ? wqS.size() : wqW.size();
      check(sat ? "wr_pending_sat" : "wr_pending_wrap", sz != 0, 1'b1);
      if (sz != 0) begin
        if (sat) e = wqS.pop_front();
        else     e = wqW.pop_front();
        check(sat ? "wr_addr_data_sat" : "wr_addr_data_wrap", {a, d}, {e.a, e.d});
      end
    end else begin
      sz = sat ? rqS.size() : rqW.size();
      check(sat ? "rd_pending_sat" : "rd_pending_wrap", sz != 0, 1'b1);
      if (sz != 0) begin
        if (sat) ra = rqS.pop_front();
        else     ra = rqW.pop_front();
        check(sat ? "rd_addr_sat" : "rd_addr_wrap", a, ra);
      end
    end
  endtask

  // Single compare process: every SRAM access must match the next expected one, idle must be quiet.
  always @(negedge clk) begin
    chkPort(1'b1, cenS, wenS, addrS, dS);
    chkPort(1'b0, cenW, wenW, addrW, dW);
    if (!busyS) check("idle_quiet", {ifS.in_ready, cenS, doneS, ifW.in_ready, cenW, doneW}, 6'b010010);
  end

  task automatic expectWrite(input bit md, input logic [10:0] a, input logic [127:0] v);
    wr_t e;
    e.a = a;
    e.d = md ? accVec(goldS[a], v, 1'b1) : v;
    goldS[a] = e.d;
    wqS.push_back(e);
    e.d = md ? accVec(goldW[a], v, 1'b0) : v;
    goldW[a] = e.d;
    wqW.push_back(e);
  endtask

  task automatic setIn(input logic vld, input logic [127:0] dat);
    ifS.in_valid = vld;
    ifS.in_data  = dat;
    ifW.in_valid = vld;
    ifW.in_data  = dat;
  endtask

  task automatic noise();
    start     = 1'($urandom_range(1));
    mode      = 1'($urandom_range(1));
    base_addr = 11'($urandom);
    length    = 12'($urandom);
  endtask

  task automatic preload(input logic [10:0] a, input logic [127:0] v);
    plVld  = 1'b1;
    plAddr = a;
    plDat  = v;
    goldS[a] = v;
    goldW[a] = v;
    @(posedge clk); #1;
    plVld = 1'b0;
  endtask

  task automatic rstChk();
    check("rst_ctl_sat",  {ifS.in_ready, cenS, wenS, busyS, doneS}, 5'b01100);
    check("rst_bus_sat",  {addrS, dS}, '0);
    check("rst_ctl_wrap", {ifW.in_ready, cenW, wenW, busyW, doneW}, 5'b01100);
    check("rst_bus_wrap", {addrW, dW}, '0);
  endtask

  // One run: start pulse, then vectors (from vecQ, else random) with optional stalls and start/param noise.
  task automatic runXfer(input bit md, input logic [10:0] base, input int len,
                         input int stallPct, input int stall1, input int abortIdx);
    logic [127:0] v;
    logic [10:0]  a;
    bit           acc;
    bit           seen;
    int           guard;
    int           k;
    mode = md; base_addr = base; length = 12'(len); start = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < len; n++) begin
      noise();
      if (n == 1) begin
        for (int s = 0; s < stall1; s++) begin
          setIn(1'b0, randVec()); @(posedge clk); #1; noise();
        end
      end
      while ($urandom_range(99) < stallPct) begin
        setIn(1'b0, randVec()); @(posedge clk); #1; noise();
      end
      a = base + 11'(n);
      v = (vecQ.size() != 0) ? vecQ.pop_front() : randVec();
      setIn(1'b1, v);
      if (md) begin
        rqS.push_back(a);
        rqW.push_back(a);
      end else begin
        expectWrite(1'b0, a, v);
      end
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 8) begin
        @(negedge clk);
        acc = ifS.in_ready;
        @(posedge clk); #1;
        guard++;
      end
      check("accept_within_bound", acc, 1'b1);
      if (!acc) begin
        setIn(1'b0, '0); start = 1'b0;
        return;
      end
      if (md) begin
        if (n == abortIdx) begin
          setIn(1'b0, randVec());
          start = 1'b0;
          reset = 1'b0;
          #1;
          rstChk();
          repeat (3) @(posedge clk);
          #1;
          reset = 1'b1;
          return;
        end
        expectWrite(1'b1, a, v);
        check("wb_not_ready", ifS.in_ready, 1'b0);
      end
    end
    setIn(1'b0, randVec());
    start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 6) begin
      @(negedge clk);
      k++;
      if (doneS) begin
        seen = 1'b1;
        check("done_busy", {busyS, doneW, busyW}, 3'b111);
      end
    end
    check("done_latency", k, (len == 0) ? 1 : (md ? 2 : 1));
    @(negedge clk);
    check("done_single_pulse", {doneS, busyS, doneW, busyW}, 4'b0000);
    check("queues_drained", wqS.size() + wqW.size() + rqS.size() + rqW.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [127:0] ovw [0:3];
  logic [127:0] wrp [0:2];
  int           bad;

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
    setIn(1'b0, '0);
    plVld = 1'b0; plAddr = '0; plDat = '0;
    fillAll = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      goldS[a] = fillVec(a);
      goldW[a] = fillVec(a);
    end
    #3;
    rstChk();
    @(posedge clk); #1;
    fillAll = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Overwrite, 4 back-to-back vectors at 0x010.
    for (int n = 0; n < 4; n++) begin
      ovw[n] = randVec();
      vecQ.push_back(ovw[n]);
    end
    runXfer(1'b0, 11'h010, 4, 0, 0, -1);
    for (int n = 0; n < 4; n++) check("ovw_ram", ramS[11'h010 + 11'(n)], ovw[n]);

    // Accumulate without overflow: 100 + (-30) = 70 in every lane.
    preload(11'h020, {8{16'd100}});
    vecQ.push_back({8{16'hFFE2}});
    runXfer(1'b1, 11'h020, 1, 0, 0, -1);
    check("acc70_sat",  ramS[11'h020], {8{16'd70}});
    check("acc70_wrap", ramW[11'h020], {8{16'd70}});

    // Overflow both ways: clamp vs wrap.
    preload(11'h100, {8{16'd32000}});
    preload(11'h101, {8{16'h8300}});
    vecQ.push_back({8{16'd1000}});
    vecQ.push_back({8{16'hFC18}});
    runXfer(1'b1, 11'h100, 2, 0, 0, -1);
    check("sat_pos",  ramS[11'h100], {8{16'h7FFF}});
    check("sat_neg",  ramS[11'h101], {8{16'h8000}});
    check("wrap_pos", ramW[11'h100], {8{16'h80E8}});
    check("wrap_neg", ramW[11'h101], {8{16'h7F18}});

    // Address wrap across the top of the SRAM.
    for (int n = 0; n < 3; n++) begin
      wrp[n] = randVec();
      vecQ.push_back(wrp[n]);
    end
    runXfer(1'b0, 11'h7FE, 3, 0, 0, -1);
    check("wrap_7fe", ramS[11'h7FE], wrp[0]);
    check("wrap_7ff", ramS[11'h7FF], wrp[1]);
    check("wrap_000", ramS[11'h000], wrp[2]);

    // Stall of 5 cycles after the first vector, with start noise during the run.
    runXfer(1'b1, 11'h200, 3, 0, 5, -1);

    // Zero-length run.
    runXfer(1'b1, 11'h400, 0, 0, 0, -1);

    // Reset during write-back of vector 1 of 4, then a clean rerun.
    runXfer(1'b1, 11'h300, 4, 0, 0, 1);
    check("abort_v0_written", ramS[11'h300], goldS[11'h300]);
    check("abort_v1_untouched", ramS[11'h301], fillVec(11'h301));
    runXfer(1'b1, 11'h300, 4, 20, 0, -1);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      runXfer(1'($urandom_range(1)), 11'($urandom), int'($urandom_range(40, 1)), 30, 0, -1);
    end

    // Full-depth overwrite.
    runXfer(1'b0, 11'h123, 2048, 0, 0, -1);
    runXfer(1'b1, 11'h5A5, 64, 25, 0, -1);

    bad = 0;
    for (int a = 0; a < 2048; a++) if (ramS[a] !== goldS[a]) bad++;
    check("ram_sweep_sat", bad, 0);
    bad = 0;
    for (int a = 0; a < 2048; a++) if (ramW[a] !== goldW[a]) bad++;
    check("ram_sweep_wrap", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
